// File: rtl/scurve_sweep_scheduler_pkg.sv
// Shared state encoding, header tag and default widths for the S-curve sweep scheduler.
package scurve_sweep_scheduler_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_WAIT_SC, ST_SETTLE, ST_HEADER, ST_ARM,
        ST_RUN, ST_DRAIN, ST_ACK, ST_NEXT, ST_DONE
    } sweepState_t;

    localparam int          DEF_DAC_W      = 10;
    localparam int          DEF_SC_TIMEOUT = 100000;
    localparam int          DEF_ARM_DELAY  = 64;
    localparam logic [15:0] DEF_HEADER_TAG = 16'h5343;
    localparam int          TIMER_W        = 17;
endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector; one-cycle pulse per input edge.
// Latency 2-3 Clk cycles from the asynchronous edge; no backpressure.
module sync_edge_detect (
    input  logic Clk,
    input  logic reset_n,
    input  logic asyncIn,
    output logic risePulse
);
    logic [2:0] syncReg;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) syncReg <= '0;
        else          syncReg <= {syncReg[1:0], asyncIn};
    end

    assign risePulse = syncReg[1] & ~syncReg[2];
endmodule

// File: rtl/scurve_sweep_scheduler.sv
// Steps SlaveDaq through a DAC threshold sweep: load, settle, header, arm, run, drain, ack per point.
// Data mux is zero-latency pass-through except the 2-cycle header; no backpressure on the USB stream.
module scurve_sweep_scheduler
    import scurve_sweep_scheduler_pkg::*;
#(
    parameter int          DAC_W      = DEF_DAC_W,
    parameter int          SC_TIMEOUT = DEF_SC_TIMEOUT,
    parameter int          ARM_DELAY  = DEF_ARM_DELAY,
    parameter logic [15:0] HEADER_TAG = DEF_HEADER_TAG
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             SweepStart,
    input  logic             SweepStop,
    input  logic [DAC_W-1:0] StartDac,
    input  logic [DAC_W-1:0] EndDac,
    input  logic [DAC_W-1:0] DacStep,
    input  logic [15:0]      TrigPerStep,
    input  logic [15:0]      SettleTime,
    input  logic             AcqStart,
    output logic [DAC_W-1:0] DacValue,
    output logic             ScLoadStart,
    input  logic             ScLoadDone,
    output logic             DaqModuleStart,
    input  logic             DaqAllDone,
    output logic             DaqTransmitDone,
    input  logic [15:0]      DaqData,
    input  logic             DaqData_en,
    output logic [15:0]      OutData,
    output logic             OutData_en,
    output logic             Busy,
    output logic             SweepDone,
    output logic             SweepError
);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(SC_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ARM_LAST     = TIMER_W'(ARM_DELAY - 1);

    sweepState_t        state, stateNext;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        trigCnt;
    logic               stopReq, stopAny;
    logic               acqPulse, sweepPulse;
    logic [16:0]        trigSum, trigTarget;
    logic [DAC_W-1:0]   stepEff;
    logic [DAC_W:0]     nextSum;
    logic               scTimeout;

    sync_edge_detect uAcqSync   (.Clk(Clk), .reset_n(reset_n), .asyncIn(AcqStart),   .risePulse(acqPulse));
    sync_edge_detect uSweepSync (.Clk(Clk), .reset_n(reset_n), .asyncIn(SweepStart), .risePulse(sweepPulse));

    // A stop seen in ARM/RUN/DRAIN/ACK is remembered so NEXT still ends the sweep after the level drops.
    assign stopAny    = SweepStop | stopReq;
    assign trigSum    = {1'b0, trigCnt} + 17'(acqPulse);
    assign trigTarget = {1'b0, (TrigPerStep == 16'd0) ? 16'd1 : TrigPerStep};
    assign stepEff    = (DacStep == '0) ? DAC_W'(1) : DacStep;
    assign nextSum    = {1'b0, DacValue} + {1'b0, stepEff};
    assign scTimeout  = (state == ST_WAIT_SC) && !stopAny && !ScLoadDone && (timer == TIMEOUT_LAST);

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:    if (sweepPulse) stateNext = ST_LOAD;
            ST_LOAD:    stateNext = stopAny ? ST_DONE : ST_WAIT_SC;
            ST_WAIT_SC: begin
                if (stopAny || scTimeout) stateNext = ST_DONE;
                else if (ScLoadDone)      stateNext = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (stopAny)                          stateNext = ST_DONE;
                else if (timer >= {1'b0, SettleTime}) stateNext = ST_HEADER;
            end
            ST_HEADER:  if (timer[0]) stateNext = stopAny ? ST_DONE : ST_ARM;
            ST_ARM: begin
                if (stopAny)                stateNext = ST_DRAIN;
                else if (timer == ARM_LAST) stateNext = ST_RUN;
            end
            ST_RUN:     if (stopAny || (trigSum >= trigTarget)) stateNext = ST_DRAIN;
            ST_DRAIN:   if (DaqAllDone) stateNext = ST_ACK;
            ST_ACK:     if (!DaqAllDone) stateNext = ST_NEXT;
            ST_NEXT:    stateNext = (stopAny || (nextSum > {1'b0, EndDac})) ? ST_DONE : ST_LOAD;
            ST_DONE:    stateNext = ST_IDLE;
            default:    stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            trigCnt    <= '0;
            DacValue   <= '0;
            SweepDone  <= 1'b0;
            SweepError <= 1'b0;
            stopReq    <= 1'b0;
        end else begin
            state   <= stateNext;
            timer   <= (stateNext != state) ? '0 : timer + 1'b1;
            trigCnt <= (state == ST_RUN) ? trigSum[15:0] : '0;
            if (state == ST_IDLE && sweepPulse) begin
                DacValue   <= StartDac;
                SweepDone  <= 1'b0;
                SweepError <= 1'b0;
                stopReq    <= 1'b0;
            end else if (state == ST_DONE) begin
                SweepDone <= 1'b1;
                stopReq   <= 1'b0;
            end else if (SweepStop && state != ST_IDLE) begin
                stopReq <= 1'b1;
            end
            if (scTimeout) SweepError <= 1'b1;
            if (state == ST_NEXT && stateNext == ST_LOAD) DacValue <= nextSum[DAC_W-1:0];
        end
    end

    assign ScLoadStart     = (state == ST_LOAD);
    assign DaqModuleStart  = (state == ST_ARM) || (state == ST_RUN);
    assign DaqTransmitDone = (state == ST_ACK);
    assign Busy            = (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        OutData    = DaqData;
        OutData_en = DaqData_en;
        if (state == ST_HEADER) begin
            OutData    = timer[0] ? 16'(DacValue) : HEADER_TAG;
            OutData_en = 1'b1;
        end
    end
endmodule
